// File: rtl/vga_bw_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_bw_sync_gen
// Purpose  : 640x480@60Hz VGA timing generator with a 1-bit (black/white)
//            test-pattern output. Free-running horizontal/vertical counters
//            are decoded combinationally into hsync, vsync and video, so the
//            outputs carry no extra pipeline latency against the counters.
// Ports    : clk_25mhz  in   1  pixel clock (25 MHz), the only clock
//            reset      in   1  synchronous, active-low reset
//            hsync      out  1  horizontal sync, active level = SYNC_POL
//            vsync      out  1  vertical sync, active level = SYNC_POL
//            video      out  1  pixel value, 1 = white, 0 = black
// Revision : 1.0  initial release
// ============================================================================
module vga_bw_sync_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int SYNC_POL  = 1,
   parameter int PATTERN   = 0,
   parameter int CELL_LOG2 = 5
) (
   input  logic clk_25mhz,
   input  logic reset,
   output logic hsync,
   output logic vsync,
   output logic video
);

   // Timing landmarks, all expressed as counter values.
   localparam logic [9:0] c_h_last     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] c_v_last     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] c_hs_start   = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] c_hs_end     = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] c_vs_start   = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] c_vs_end     = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam logic [9:0] c_h_vis      = 10'(H_VISIBLE);
   localparam logic [9:0] c_v_vis      = 10'(V_VISIBLE);
   localparam logic [9:0] c_h_vis_last = 10'(H_VISIBLE - 1);
   localparam logic [9:0] c_v_vis_last = 10'(V_VISIBLE - 1);
   localparam logic       c_sync_on    = (SYNC_POL != 0);

   logic [9:0] h_count;
   logic [9:0] v_count;

   logic w_h_wrap;
   logic w_v_wrap;
   logic w_hs_active;
   logic w_vs_active;
   logic w_visible;
   logic w_pattern_bit;

   assign w_h_wrap = (h_count == c_h_last);
   assign w_v_wrap = (v_count == c_v_last);

   // Line counter advances only on the pixel that ends a line; the last pixel
   // of the last line therefore wraps both counters on the same edge.
   always_ff @(posedge clk_25mhz) begin
      if (!reset) begin
         h_count <= 10'd0;
         v_count <= 10'd0;
      end else if (w_h_wrap) begin
         h_count <= 10'd0;
         if (w_v_wrap) begin
            v_count <= 10'd0;
         end else begin
            v_count <= v_count + 10'd1;
         end
      end else begin
         h_count <= h_count + 10'd1;
      end
   end

   assign w_hs_active = (h_count >= c_hs_start) && (h_count <= c_hs_end);
   assign w_vs_active = (v_count >= c_vs_start) && (v_count <= c_vs_end);
   assign w_visible   = (h_count < c_h_vis) && (v_count < c_v_vis);

   // Pattern selection is fixed at elaboration; unknown codes fall back to
   // the checkerboard.
   generate
      if (PATTERN == 1) begin : g_bars
         assign w_pattern_bit = h_count[CELL_LOG2];
      end else if (PATTERN == 2) begin : g_white
         assign w_pattern_bit = 1'b1;
      end else if (PATTERN == 3) begin : g_border
         assign w_pattern_bit = (h_count == 10'd0) || (h_count == c_h_vis_last) ||
                                (v_count == 10'd0) || (v_count == c_v_vis_last);
      end else begin : g_checker
         assign w_pattern_bit = h_count[CELL_LOG2] ^ v_count[CELL_LOG2];
      end
   endgenerate

   // Outputs are forced idle directly from reset so they are clean even
   // before the first clock edge has cleared the counters.
   always_comb begin
      hsync = ~c_sync_on;
      vsync = ~c_sync_on;
      video = 1'b0;
      if (reset) begin
         hsync = w_hs_active ? c_sync_on : ~c_sync_on;
         vsync = w_vs_active ? c_sync_on : ~c_sync_on;
         video = w_visible & w_pattern_bit;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_bw_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_bw_sync_gen
// Purpose  : Self-checking bench for vga_bw_sync_gen. Several instances with
//            different timing/pattern parameters run side by side; a position
//            model derived from the number of clocks since reset release
//            predicts every output each cycle, and literal expectations pin
//            the landmark points of the timing.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_bw_sync_gen;

   typedef struct packed {
      int hv; int hf; int hs; int hb;
      int vv; int vf; int vs; int vb;
      int pol; int pat; int cl;
   } cfg_t;

   localparam cfg_t C_CHK = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 0, 5};
   localparam cfg_t C_WHT = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 2, 5};
   localparam cfg_t C_BRD = '{64, 4, 8, 4, 20, 2, 2, 3, 0, 3, 2};
   localparam cfg_t C_BAR = '{64, 4, 8, 4, 20, 2, 2, 3, 1, 1, 2};
   localparam cfg_t C_UNK = '{64, 4, 8, 4, 20, 2, 2, 3, 1, 7, 2};

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic hs_chk, vs_chk, vid_chk;
   logic hs_wht, vs_wht, vid_wht;
   logic hs_brd, vs_brd, vid_brd;
   logic hs_bar, vs_bar, vid_bar;
   logic hs_unk, vs_unk, vid_unk;

   int errors = 0;
   int checks = 0;
   int n = 0;
   logic valid = 1'b0;

   always #20 clk = ~clk;

   vga_bw_sync_gen u_chk (.clk_25mhz(clk), .reset(reset), .hsync(hs_chk), .vsync(vs_chk), .video(vid_chk));
   vga_bw_sync_gen #(.PATTERN(2)) u_wht (.clk_25mhz(clk), .reset(reset), .hsync(hs_wht), .vsync(vs_wht), .video(vid_wht));
   vga_bw_sync_gen #(.H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4), .V_VISIBLE(20), .V_FRONT(2),
                     .V_SYNC(2), .V_BACK(3), .SYNC_POL(0), .PATTERN(3), .CELL_LOG2(2))
      u_brd (.clk_25mhz(clk), .reset(reset), .hsync(hs_brd), .vsync(vs_brd), .video(vid_brd));
   vga_bw_sync_gen #(.H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4), .V_VISIBLE(20), .V_FRONT(2),
                     .V_SYNC(2), .V_BACK(3), .SYNC_POL(1), .PATTERN(1), .CELL_LOG2(2))
      u_bar (.clk_25mhz(clk), .reset(reset), .hsync(hs_bar), .vsync(vs_bar), .video(vid_bar));
   vga_bw_sync_gen #(.H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4), .V_VISIBLE(20), .V_FRONT(2),
                     .V_SYNC(2), .V_BACK(3), .SYNC_POL(1), .PATTERN(7), .CELL_LOG2(2))
      u_unk (.clk_25mhz(clk), .reset(reset), .hsync(hs_unk), .vsync(vs_unk), .video(vid_unk));

   // Screen position is simply the clock count since release, folded by the
   // line and frame lengths.
   function automatic logic [22:0] model(cfg_t c, int cyc, logic rst);
      int ht, vt, h, v;
      logic on, hs, vs, vid;
      ht  = c.hv + c.hf + c.hs + c.hb;
      vt  = c.vv + c.vf + c.vs + c.vb;
      h   = cyc % ht;
      v   = (cyc / ht) % vt;
      on  = (c.pol != 0);
      hs  = (h >= c.hv + c.hf && h < c.hv + c.hf + c.hs) ? on : !on;
      vs  = (v >= c.vv + c.vf && v < c.vv + c.vf + c.vs) ? on : !on;
      vid = 1'b0;
      if (h < c.hv && v < c.vv) begin
         case (c.pat)
            1:       vid = ((h >> c.cl) % 2) == 1;
            2:       vid = 1'b1;
            3:       vid = (h == 0) || (h == c.hv - 1) || (v == 0) || (v == c.vv - 1);
            default: vid = (((h >> c.cl) + (v >> c.cl)) % 2) == 1;
         endcase
      end
      if (!rst) begin
         hs  = !on;
         vs  = !on;
         vid = 1'b0;
      end
      return {h[9:0], v[9:0], hs, vs, vid};
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      valid <= 1'b1;
      if (!reset) n <= 0;
      else        n <= n + 1;
   end

   always @(negedge clk) begin
      if (valid) begin
         chk($sformatf("u_chk n=%0d", n), 32'({u_chk.h_count, u_chk.v_count, hs_chk, vs_chk, vid_chk}), 32'(model(C_CHK, n, reset)));
         chk($sformatf("u_wht n=%0d", n), 32'({u_wht.h_count, u_wht.v_count, hs_wht, vs_wht, vid_wht}), 32'(model(C_WHT, n, reset)));
         chk($sformatf("u_brd n=%0d", n), 32'({u_brd.h_count, u_brd.v_count, hs_brd, vs_brd, vid_brd}), 32'(model(C_BRD, n, reset)));
         chk($sformatf("u_bar n=%0d", n), 32'({u_bar.h_count, u_bar.v_count, hs_bar, vs_bar, vid_bar}), 32'(model(C_BAR, n, reset)));
         chk($sformatf("u_unk n=%0d", n), 32'({u_unk.h_count, u_unk.v_count, hs_unk, vs_unk, vid_unk}), 32'(model(C_UNK, n, reset)));
         if (reset) begin
            case (n)
               0:     chk("chk video(0,0)", 32'(vid_chk), 32'd0);
               3:     chk("bar video h=3", 32'(vid_bar), 32'd0);
               4:     chk("bar video h=4", 32'(vid_bar), 32'd1);
               5:     chk("brd top row", 32'(vid_brd), 32'd1);
               32:    chk("chk video(32,0)", 32'(vid_chk), 32'd1);
               67:    chk("brd hsync idle", 32'(hs_brd), 32'd1);
               68:    chk("brd hsync active low", 32'(hs_brd), 32'd0);
               84:    chk("unk video(4,1)", 32'(vid_unk), 32'd1);
               85:    chk("brd interior", 32'(vid_brd), 32'd0);
               143:   chk("brd right col", 32'(vid_brd), 32'd1);
               324:   chk("unk video(4,4)", 32'(vid_unk), 32'd0);
               639:   chk("wht last visible", 32'(vid_wht), 32'd1);
               640:   chk("wht h blank", 32'(vid_wht), 32'd0);
               655:   chk("hsync before", 32'(hs_chk), 32'd0);
               656:   chk("hsync first", 32'(hs_chk), 32'd1);
               751:   chk("hsync last", 32'(hs_chk), 32'd1);
               752:   chk("hsync after", 32'(hs_chk), 32'd0);
               799:   chk("line end h/v", 32'({u_chk.h_count, u_chk.v_count}), {12'd0, 10'd799, 10'd0});
               800:   chk("line 1 start", 32'({u_chk.h_count, u_chk.v_count}), {12'd0, 10'd0, 10'd1});
               1456:  chk("hsync line 1", 32'(hs_chk), 32'd1);
               1600:  chk("line 2 start", 32'({u_chk.h_count, u_chk.v_count}), {12'd0, 10'd0, 10'd2});
               1759:  chk("bar vsync before", 32'(vs_bar), 32'd0);
               1760:  chk("bar vsync first", 32'(vs_bar), 32'd1);
               1919:  chk("bar vsync last", 32'(vs_bar), 32'd1);
               1920:  chk("bar vsync after", 32'(vs_bar), 32'd0);
               2159:  chk("bar frame end", 32'({u_bar.h_count, u_bar.v_count}), {12'd0, 10'd79, 10'd26});
               2160:  chk("bar frame wrap", 32'({u_bar.h_count, u_bar.v_count}), 32'd0);
               25600: chk("chk video(0,32)", 32'(vid_chk), 32'd1);
               25632: chk("chk video(32,32)", 32'(vid_chk), 32'd0);
               default: ;
            endcase
         end
      end
   end

   initial begin
      reset = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("reset counters", 32'({u_chk.h_count, u_chk.v_count}), 32'd0);
      chk("reset syncs", 32'({hs_chk, vs_chk, vid_chk}), 32'd0);
      chk("reset syncs pol0", 32'({hs_brd, vs_brd, vid_brd}), 32'b110);
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (27000) @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("midframe reset chk", 32'({u_chk.h_count, u_chk.v_count}), 32'd0);
      chk("midframe reset bar", 32'({u_bar.h_count, u_bar.v_count}), 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (2500) @(posedge clk);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
